// File: rtl/cry_lut_pipe_if.sv
// Pixel handshake and table write port of the colour lookup pipeline.
interface cry_lut_pipe_if #(
  parameter int unsigned CH = 3,
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8,
  parameter int unsigned IW = 8
);
  localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    in_idx;
  logic [IW-1:0]    in_y;
  logic             in_bypass;
  logic             out_valid;
  logic             out_ready;
  logic [CH*DW-1:0] out_data;
  logic             wr_en;
  logic [CHW-1:0]   wr_ch;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;

  modport master (
    output in_valid, in_idx, in_y, in_bypass, out_ready,
    output wr_en, wr_ch, wr_addr, wr_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_idx, in_y, in_bypass, out_ready,
    input  wr_en, wr_ch, wr_addr, wr_data,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/cry_lut_pipe.sv
// Multi-channel runtime-loadable colour lookup pipeline.
// Pixel {index, intensity} -> CH components, each scale(table_k[index], intensity).
// Three register stages (input, table read, scale) with a single global stall.
module cry_lut_pipe #(
  parameter int unsigned CH = 3,
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8,
  parameter int unsigned IW = 8
) (
  input logic           sys_clk,
  input logic           reset,
  cry_lut_pipe_if.slave bus
);

  logic             en;
  logic [AW-1:0]    idx1;
  logic [IW-1:0]    y1;
  logic [IW-1:0]    y2;
  logic             byp1;
  logic             byp2;
  logic             v1;
  logic             v2;
  logic [CH*DW-1:0] c_next;

  assign en          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  // Input stage and control forwarding alongside the table read
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      idx1 <= '0;
      y1   <= '0;
      byp1 <= 1'b0;
      v1   <= 1'b0;
      y2   <= '0;
      byp2 <= 1'b0;
      v2   <= 1'b0;
    end else if (en) begin
      idx1 <= bus.in_idx;
      y1   <= bus.in_y;
      byp1 <= bus.in_bypass;
      v1   <= bus.in_valid;
      y2   <= y1;
      byp2 <= byp1;
      v2   <= v1;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_tbl
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd;

    // Block RAM: write port free-running, read register stalls with the pipe.
    // Both in one block so a same-entry read sees the pre-write contents.
    always_ff @(posedge sys_clk) begin
      if (bus.wr_en && (int'(bus.wr_ch) == k))
        mem[bus.wr_addr] <= bus.wr_data;
      if (en)
        rd <= mem[idx1];
    end

    // t*y + t is t*(y+1); the top DW bits never exceed t, so no clamp is needed
    assign c_next[k*DW +: DW] = byp2 ? rd :
      DW'(((DW+IW)'(rd) * (DW+IW)'(y2) + (DW+IW)'(rd)) >> IW);
  end

  // Output register; holds while downstream stalls
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else if (en) begin
      bus.out_valid <= v2;
      bus.out_data  <= c_next;
    end
  end

endmodule
